// File: rtl/i2s_frame_serializer.sv
// Slave-side I2S transmitter: follows an externally generated BCK/LRCK frame
// (oversampled on OSC_CLK) and shifts buffered stereo samples out MSB first.
module i2s_frame_serializer #(
`ifdef _24BitAudio
    parameter int DATA_WIDTH = 24,
`else
    parameter int DATA_WIDTH = 16,
`endif
    parameter int SLOT_BITS  = 32
) (
    input  logic                  OSC_CLK,
    input  logic                  iRST_N,
    input  logic                  iAUD_BCK,
    input  logic                  iAUD_LRCK,
    input  logic [DATA_WIDTH-1:0] iL_DATA,
    input  logic [DATA_WIDTH-1:0] iR_DATA,
    input  logic                  iSAMPLE_VALID,
    output logic                  oSAMPLE_READY,
    output logic                  oAUD_DATA,
    output logic                  oUNDERRUN,
    output logic                  oFRAME_ERR
);

    localparam int         PAD_BITS = SLOT_BITS - DATA_WIDTH;
    localparam logic [5:0] SLOT_CNT = 6'(SLOT_BITS);
    localparam logic [5:0] CNT_MAX  = 6'd63;

    logic [2:0]            bck_q,    bck_d;
    logic [1:0]            lrck_q,   lrck_d;
    logic                  lr_last_q, lr_last_d;
    logic [SLOT_BITS-1:0]  sh_q,     sh_d;
    logic                  data_q,   data_d;
    logic [5:0]            cnt_q,    cnt_d;
    logic                  locked_q, locked_d;
    logic                  empty_q,  empty_d;
    logic [DATA_WIDTH-1:0] hold_l_q, hold_l_d;
    logic [DATA_WIDTH-1:0] hold_r_q, hold_r_d;
    logic [DATA_WIDTH-1:0] rsave_q,  rsave_d;
    logic                  und_q,    und_d;
    logic                  ferr_q,   ferr_d;

    logic                  fall_s;
    logic                  lr_now_s;
    logic                  boundary_s;
    logic [DATA_WIDTH-1:0] word_s;

    // Next-state: synchronisers, holding-register handshake, shifter and frame check
    always_comb begin
        bck_d      = {bck_q[1:0], iAUD_BCK};
        lrck_d     = {lrck_q[0], iAUD_LRCK};
        lr_last_d  = lr_last_q;
        sh_d       = sh_q;
        data_d     = data_q;
        cnt_d      = cnt_q;
        locked_d   = locked_q;
        empty_d    = empty_q;
        hold_l_d   = hold_l_q;
        hold_r_d   = hold_r_q;
        rsave_d    = rsave_q;
        und_d      = 1'b0;
        ferr_d     = 1'b0;
        word_s     = '0;
        fall_s     = bck_q[2] & ~bck_q[1];
        lr_now_s   = lrck_q[1];
        boundary_s = fall_s & (lr_now_s != lr_last_q);

        if (iSAMPLE_VALID && empty_q) begin
            hold_l_d = iL_DATA;
            hold_r_d = iR_DATA;
            empty_d  = 1'b0;
        end else begin
            empty_d  = empty_q;
        end

        // A write racing an empty-register left boundary stays queued for the next frame.
        if (fall_s) begin
            data_d    = sh_q[SLOT_BITS-1];
            lr_last_d = lr_now_s;
            if (boundary_s) begin
                cnt_d    = 6'd1;
                locked_d = 1'b1;
                if (locked_q && (cnt_q != SLOT_CNT)) begin
                    ferr_d = 1'b1;
                end else begin
                    ferr_d = 1'b0;
                end
                if (!lr_now_s) begin
                    if (!empty_q) begin
                        word_s  = hold_l_q;
                        rsave_d = hold_r_q;
                        empty_d = 1'b1;
                    end else begin
                        word_s  = '0;
                        rsave_d = '0;
                        und_d   = 1'b1;
                    end
                end else begin
                    word_s = rsave_q;
                end
                sh_d = {word_s, {PAD_BITS{1'b0}}};
            end else begin
                sh_d  = {sh_q[SLOT_BITS-2:0], 1'b0};
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 6'd1;
            end
        end else begin
            sh_d = sh_q;
        end
    end

    // State register with asynchronous active-low reset
    always_ff @(posedge OSC_CLK or negedge iRST_N) begin
        if (!iRST_N) begin
            bck_q     <= 3'b000;
            lrck_q    <= 2'b00;
            lr_last_q <= 1'b0;
            sh_q      <= '0;
            data_q    <= 1'b0;
            cnt_q     <= 6'd0;
            locked_q  <= 1'b0;
            empty_q   <= 1'b1;
            hold_l_q  <= '0;
            hold_r_q  <= '0;
            rsave_q   <= '0;
            und_q     <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            bck_q     <= bck_d;
            lrck_q    <= lrck_d;
            lr_last_q <= lr_last_d;
            sh_q      <= sh_d;
            data_q    <= data_d;
            cnt_q     <= cnt_d;
            locked_q  <= locked_d;
            empty_q   <= empty_d;
            hold_l_q  <= hold_l_d;
            hold_r_q  <= hold_r_d;
            rsave_q   <= rsave_d;
            und_q     <= und_d;
            ferr_q    <= ferr_d;
        end
    end

    assign oSAMPLE_READY = empty_q;
    assign oAUD_DATA     = data_q;
    assign oUNDERRUN     = und_q;
    assign oFRAME_ERR    = ferr_q;

endmodule

// File: tb/tb_i2s_frame_serializer.sv
// Directed bench for i2s_frame_serializer: expected serial bits are queued as
// BCK cycles are driven and checked just before the following BCK fall.
module tb_i2s_frame_serializer;

    localparam int DW = 16;
    localparam int SB = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          bck;
    logic          lrck;
    logic          valid;
    logic [DW-1:0] l_data;
    logic [DW-1:0] r_data;
    logic          ready;
    logic          sdata;
    logic          und;
    logic          ferr;

    always #5 clk = ~clk;

    i2s_frame_serializer #(.DATA_WIDTH(DW), .SLOT_BITS(SB)) dut (
        .OSC_CLK      (clk),
        .iRST_N       (rst_n),
        .iAUD_BCK     (bck),
        .iAUD_LRCK    (lrck),
        .iL_DATA      (l_data),
        .iR_DATA      (r_data),
        .iSAMPLE_VALID(valid),
        .oSAMPLE_READY(ready),
        .oAUD_DATA    (sdata),
        .oUNDERRUN    (und),
        .oFRAME_ERR   (ferr)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    int          und_cnt = 0;
    int          ferr_cnt = 0;
    int          acc_cnt = 0;
    logic        exp_q[$];
    logic [31:0] acc_q[$];
    bit          churn = 1'b0;

    // Pulse-cycle counters and handshake capture
    always @(posedge clk) begin
        if (und === 1'b1) und_cnt++;
        if (ferr === 1'b1) ferr_cnt++;
        if (rst_n === 1'b1 && valid === 1'b1 && ready === 1'b1) begin
            acc_cnt++;
            acc_q.push_back({l_data, r_data});
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic churn_data();
        if (churn) begin
            l_data = DW'($urandom);
            r_data = DW'($urandom);
        end
    endtask

    // One BCK period; optionally writes a pair in the cycle the fall is acted on
    task automatic bck_cycle(input logic lr, input bit wr_evt, input logic [31:0] wpair);
        logic eb;
        @(negedge clk);
        bck  = 1'b0;
        lrck = lr;
        churn_data();
        if (wr_evt) begin
            @(negedge clk);
            @(negedge clk);
            valid  = 1'b1;
            l_data = wpair[31:16];
            r_data = wpair[15:0];
            @(negedge clk);
            valid  = 1'b0;
            repeat (2) @(negedge clk);
        end else begin
            repeat (5) @(negedge clk);
        end
        bck = 1'b1;
        churn_data();
        repeat (5) @(negedge clk);
        eb = (exp_q.size() > 0) ? exp_q.pop_front() : 1'b0;
        chk("sdata", {31'd0, sdata}, {31'd0, eb});
    endtask

    // n BCK periods at one LRCK level; expected: delay bit, word MSB first, zeros
    task automatic half(input logic lr, input logic [DW-1:0] w, input int n,
                        input bit wr_evt, input logic [31:0] wpair);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back((i >= 1 && i <= DW) ? w[DW-i] : 1'b0);
            bck_cycle(lr, wr_evt && (i == 0), wpair);
        end
    endtask

    task automatic frame(input logic [DW-1:0] wl, input logic [DW-1:0] wr);
        half(1'b0, wl, SB, 1'b0, 32'd0);
        half(1'b1, wr, SB, 1'b0, 32'd0);
    endtask

    task automatic write_pair(input logic [DW-1:0] wl, input logic [DW-1:0] wr);
        @(negedge clk);
        chk("ready_before_write", {31'd0, ready}, 32'd1);
        valid  = 1'b1;
        l_data = wl;
        r_data = wr;
        @(negedge clk);
        valid  = 1'b0;
        chk("ready_after_write", {31'd0, ready}, 32'd0);
    endtask

    int          u0;
    int          f0;
    int          a0;
    logic [31:0] pair;

    initial begin
        rst_n  = 1'b0;
        bck    = 1'b1;
        lrck   = 1'b0;
        valid  = 1'b0;
        l_data = '0;
        r_data = '0;

        // T1: reset held while the frame clocks run
        repeat (3) @(negedge clk);
        half(1'b0, 16'h0000, 8, 1'b0, 32'd0);
        half(1'b1, 16'h0000, 8, 1'b0, 32'd0);
        chk("t1_ready_in_reset", {31'd0, ready}, 32'd1);
        chk("t1_und_in_reset", und_cnt, 32'd0);
        chk("t1_ferr_in_reset", ferr_cnt, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // T2: basic frame; first boundary (rising) must not flag a frame error
        write_pair(16'hA5C3, 16'h8001);
        half(1'b1, 16'h0000, SB, 1'b0, 32'd0);
        chk("t2_ferr_first_boundary", ferr_cnt, 32'd0);
        chk("t2_ready_still_full", {31'd0, ready}, 32'd0);
        half(1'b0, 16'hA5C3, SB, 1'b0, 32'd0);
        chk("t2_ready_after_left_load", {31'd0, ready}, 32'd1);
        half(1'b1, 16'h8001, SB, 1'b0, 32'd0);
        chk("t2_no_underrun", und_cnt, 32'd0);
        chk("t2_no_ferr", ferr_cnt, 32'd0);

        // T3: underrun frame, then a write racing the left boundary
        u0 = und_cnt;
        frame(16'h0000, 16'h0000);
        chk("t3_underrun_one_cycle", und_cnt - u0, 32'd1);
        u0 = und_cnt;
        half(1'b0, 16'h0000, SB, 1'b1, {16'h1234, 16'h5678});
        chk("t3_race_is_underrun", und_cnt - u0, 32'd1);
        chk("t3_race_pair_held", {31'd0, ready}, 32'd0);
        half(1'b1, 16'h0000, SB, 1'b0, 32'd0);
        u0 = und_cnt;
        frame(16'h1234, 16'h5678);
        chk("t3_next_frame_no_underrun", und_cnt - u0, 32'd0);
        chk("t3_ready_after_send", {31'd0, ready}, 32'd1);

        // T4: VALID held with changing data over four frames
        acc_q.delete();
        u0 = und_cnt;
        @(negedge clk);
        churn  = 1'b1;
        l_data = 16'h0F1E;
        r_data = 16'h2D3C;
        valid  = 1'b1;
        repeat (2) @(negedge clk);
        for (int f = 0; f < 5; f++) begin
            if (f == 4) valid = 1'b0;
            chk("t4_pending_pairs", acc_q.size(), 32'd1);
            pair = (acc_q.size() > 0) ? acc_q.pop_front() : 32'd0;
            a0 = acc_cnt;
            frame(pair[31:16], pair[15:0]);
            chk("t4_accepts_per_frame", acc_cnt - a0, (f < 4) ? 32'd1 : 32'd0);
        end
        churn = 1'b0;
        chk("t4_no_underrun", und_cnt - u0, 32'd0);
        chk("t4_queue_drained", acc_q.size(), 32'd0);
        chk("t4_ready_end", {31'd0, ready}, 32'd1);

        // T5: one short half-frame
        write_pair(16'h6B2D, 16'hC0DE);
        f0 = ferr_cnt;
        half(1'b0, 16'h6B2D, SB - 1, 1'b0, 32'd0);
        chk("t5_no_err_before_short_end", ferr_cnt - f0, 32'd0);
        half(1'b1, 16'hC0DE, SB, 1'b0, 32'd0);
        chk("t5_ferr_once", ferr_cnt - f0, 32'd1);
        write_pair(16'h7FFF, 16'h8000);
        f0 = ferr_cnt;
        frame(16'h7FFF, 16'h8000);
        chk("t5_recovered_no_ferr", ferr_cnt - f0, 32'd0);

        // T6: reset in the middle of a left slot
        write_pair(16'h0F0F, 16'hF00F);
        half(1'b0, 16'h0F0F, 8, 1'b0, 32'd0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t6_data_zero_on_reset", {31'd0, sdata}, 32'd0);
        chk("t6_ready_on_reset", {31'd0, ready}, 32'd1);
        half(1'b0, 16'h0000, 4, 1'b0, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        u0 = und_cnt;
        f0 = ferr_cnt;
        half(1'b0, 16'h0000, SB - 12, 1'b0, 32'd0);
        half(1'b1, 16'h0000, SB, 1'b0, 32'd0);
        write_pair(16'h3C5A, 16'h7E81);
        frame(16'h3C5A, 16'h7E81);
        chk("t6_no_underrun", und_cnt - u0, 32'd0);
        chk("t6_no_ferr", ferr_cnt - f0, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
